// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage stall/flush control for the five-stage core.
// Handles load-use, fixed-latency mul/div sequencing, data-memory wait and
// branch redirects that overlap an outstanding instruction fetch.
// Optional performance counters: define PIPE_HAZARD_PERF_EN to build them;
// otherwise perf_stall_cnt/perf_flush_cnt read as zero and no flops exist.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        d_ra1,
    input  logic [4:0]        d_ra2,
    input  logic              d_uses_ra1,
    input  logic              d_uses_ra2,
    input  logic              e_is_load,
    input  logic [4:0]        e_dst,
    input  logic              e_is_muldiv,
    input  logic              e_redirect,
    input  logic              imem_busy,
    input  logic              dmem_busy,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              md_start,
    output logic              md_done,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MD_BUSY   = 2'd1,
        DMEM_WAIT = 2'd2
    } state_e;

    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

    state_e     state_q, state_d;
    state_e     prior_q, prior_d;
    state_e     eff_state;
    logic [3:0] cnt_q, cnt_d;
    logic       redir_pend_q, redir_pend_d;
    logic       load_use;
    logic       flush_evt;

    assign load_use = e_is_load && (e_dst != 5'd0) &&
                      ((d_uses_ra1 && (e_dst == d_ra1)) ||
                       (d_uses_ra2 && (e_dst == d_ra2)));

    // DMEM_WAIT is left as soon as dmem_busy drops, so a cycle with
    // dmem_busy=0 behaves as the state that was interrupted.
    assign eff_state = (state_q == DMEM_WAIT) ? prior_q : state_q;

    // Next-state and combinational stall/flush decode, highest priority first
    always_comb begin
        state_d      = state_q;
        prior_d      = prior_q;
        cnt_d        = cnt_q;
        redir_pend_d = redir_pend_q;
        flush_evt    = 1'b0;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_m      = 1'b0;
        md_start     = 1'b0;
        md_done      = 1'b0;

        if (dmem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            state_d = DMEM_WAIT;
            prior_d = eff_state;
        end else begin
            state_d = eff_state;
            case (eff_state)
                MD_BUSY: begin
                    if (cnt_q == '0) begin
                        // Result leaves E; the whole pipe resumes this cycle.
                        md_done = 1'b1;
                        state_d = RUN;
                    end else begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
                default: begin
                    if (e_redirect) begin
                        flush_d      = 1'b1;
                        flush_e      = 1'b1;
                        stall_f      = imem_busy;
                        redir_pend_d = imem_busy;
                        flush_evt    = 1'b1;
                    end else if (e_is_muldiv) begin
                        md_start = 1'b1;
                        stall_f  = 1'b1;
                        stall_d  = 1'b1;
                        stall_e  = 1'b1;
                        flush_m  = 1'b1;
                        cnt_d    = MD_LOAD;
                        state_d  = MD_BUSY;
                    end else if (load_use) begin
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        flush_e   = 1'b1;
                        flush_evt = 1'b1;
                    end else begin
                        stall_f      = imem_busy;
                        flush_d      = imem_busy | redir_pend_q;
                        redir_pend_d = redir_pend_q & imem_busy;
                    end
                end
            endcase
        end

        if (!reset) begin
            stall_f   = 1'b0;
            stall_d   = 1'b0;
            stall_e   = 1'b0;
            stall_m   = 1'b0;
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            flush_m   = 1'b1;
            md_start  = 1'b0;
            md_done   = 1'b0;
            flush_evt = 1'b0;
        end
    end

    // Controller state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= RUN;
            prior_q      <= RUN;
            cnt_q        <= '0;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prior_q      <= prior_d;
            cnt_q        <= cnt_d;
            redir_pend_q <= redir_pend_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

    // Free-running event counters, wrapping at 2^PERF_W
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_f) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_evt) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
